// File: rtl/proc_ctrl.sv
// proc_ctrl -- control unit for the simple 9-bit processor.
//
// Latches an instruction word {III,XXX,YYY} from DIN into an internal IR at
// the fetch edge, then walks through time slots T0..T3, driving the datapath
// enables for each slot. All outputs are combinational from (slot, IR, Run)
// and are held at 0 while Reset is asserted.
//
// Ports:
//   Clock   in   1  rising-edge clock
//   Reset   in   1  asynchronous, active-high reset
//   DIN     in   9  instruction word (immediate operand during mvi T1)
//   Run     in   1  start request, only looked at in T0
//   IRin    out  1  load IR from DIN
//   Rin     out  8  one-hot register load enables
//   Rout    out  8  one-hot register bus-drive enables
//   DINout  out  1  drive DIN onto the bus
//   Gout    out  1  drive G onto the bus
//   Ain     out  1  load A from the bus
//   Gin     out  1  load G from the ALU
//   AddSub  out  1  ALU op, 0 = add, 1 = subtract
//   Done    out  1  one-cycle pulse in the final slot of an instruction
module proc_ctrl (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [8:0] DIN,
    input  logic       Run,
    output logic       IRin,
    output logic [7:0] Rin,
    output logic [7:0] Rout,
    output logic       DINout,
    output logic       Gout,
    output logic       Ain,
    output logic       Gin,
    output logic       AddSub,
    output logic       Done
);

    typedef enum logic [1:0] {
        T0 = 2'b00,
        T1 = 2'b01,
        T2 = 2'b10,
        T3 = 2'b11
    } slot_t;

    localparam logic [2:0] OP_MV  = 3'b000;
    localparam logic [2:0] OP_MVI = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;

    slot_t      slot;
    slot_t      next_slot;
    logic [8:0] ir;
    logic [2:0] opcode;
    logic [2:0] reg_x;
    logic [2:0] reg_y;

    logic       ir_load;
    logic [7:0] rin_c;
    logic [7:0] rout_c;
    logic       dinout_c;
    logic       gout_c;
    logic       ain_c;
    logic       gin_c;
    logic       addsub_c;
    logic       done_c;

    assign opcode = ir[8:6];
    assign reg_x  = ir[5:3];
    assign reg_y  = ir[2:0];

    // Same mapping as the datapath's register-enable decoder.
    function automatic logic [7:0] onehot(input logic [2:0] k);
        return 8'b1 << k;
    endfunction

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            slot <= T0;
            ir   <= '0;
        end else begin
            if (ir_load) begin
                ir <= DIN;
            end
            slot <= next_slot;
        end
    end

    always_comb begin
        next_slot = slot;
        ir_load   = 1'b0;
        rin_c     = '0;
        rout_c    = '0;
        dinout_c  = 1'b0;
        gout_c    = 1'b0;
        ain_c     = 1'b0;
        gin_c     = 1'b0;
        addsub_c  = 1'b0;
        done_c    = 1'b0;
        case (slot)
            T0: begin
                ir_load = Run;
                if (Run) begin
                    next_slot = T1;
                end
            end
            T1: begin
                next_slot = T0;
                case (opcode)
                    OP_MV: begin
                        rout_c = onehot(reg_y);
                        rin_c  = onehot(reg_x);
                        done_c = 1'b1;
                    end
                    OP_MVI: begin
                        dinout_c = 1'b1;
                        rin_c    = onehot(reg_x);
                        done_c   = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        rout_c    = onehot(reg_x);
                        ain_c     = 1'b1;
                        next_slot = T2;
                    end
                    default: begin
                        done_c = 1'b1;
                    end
                endcase
            end
            T2: begin
                // Only add/sub reach T2; anything else falls back to T0.
                next_slot = T0;
                if (opcode == OP_ADD || opcode == OP_SUB) begin
                    rout_c    = onehot(reg_y);
                    gin_c     = 1'b1;
                    addsub_c  = (opcode == OP_SUB);
                    next_slot = T3;
                end
            end
            T3: begin
                next_slot = T0;
                if (opcode == OP_ADD || opcode == OP_SUB) begin
                    gout_c = 1'b1;
                    rin_c  = onehot(reg_x);
                    done_c = 1'b1;
                end
            end
        endcase
    end

    // Reset masks every output immediately, without waiting for an edge.
    assign IRin   = ir_load  & ~Reset;
    assign Rin    = Reset ? 8'h00 : rin_c;
    assign Rout   = Reset ? 8'h00 : rout_c;
    assign DINout = dinout_c & ~Reset;
    assign Gout   = gout_c   & ~Reset;
    assign Ain    = ain_c    & ~Reset;
    assign Gin    = gin_c    & ~Reset;
    assign AddSub = addsub_c & ~Reset;
    assign Done   = done_c   & ~Reset;

endmodule

// File: tb/tb_proc_ctrl.sv
module tb_proc_ctrl;

    logic       Clock;
    logic       Reset;
    logic [8:0] DIN;
    logic       Run;
    logic       IRin;
    logic [7:0] Rin;
    logic [7:0] Rout;
    logic       DINout;
    logic       Gout;
    logic       Ain;
    logic       Gin;
    logic       AddSub;
    logic       Done;

    logic [22:0] outs;
    logic [22:0] q[$];
    int checks;
    int errors;

    proc_ctrl dut (
        .Clock (Clock),
        .Reset (Reset),
        .DIN   (DIN),
        .Run   (Run),
        .IRin  (IRin),
        .Rin   (Rin),
        .Rout  (Rout),
        .DINout(DINout),
        .Gout  (Gout),
        .Ain   (Ain),
        .Gin   (Gin),
        .AddSub(AddSub),
        .Done  (Done)
    );

    assign outs = {IRin, Rin, Rout, DINout, Gout, Ain, Gin, AddSub, Done};

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [22:0] got, input logic [22:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] oh(input logic [2:0] k);
        return 8'b1 << k;
    endfunction

    function automatic logic [22:0] pack(input logic irin, input logic [7:0] rin,
                                         input logic [7:0] rout, input logic dinout,
                                         input logic gout, input logic ain, input logic gin,
                                         input logic addsub, input logic done);
        return {irin, rin, rout, dinout, gout, ain, gin, addsub, done};
    endfunction

    // Expected output of the current cycle: idle means T0, otherwise the
    // next queued slot record of the instruction in flight.
    function automatic logic [22:0] cur_exp(input logic run);
        if (q.size() == 0) return pack(run, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        return q[0];
    endfunction

    // Queue the per-slot outputs of one instruction after its fetch.
    task automatic expand(input logic [8:0] instr);
        logic [2:0] op;
        logic [2:0] x;
        logic [2:0] y;
        op = instr[8:6];
        x  = instr[5:3];
        y  = instr[2:0];
        case (op)
            3'd0: q.push_back(pack(1'b0, oh(x), oh(y), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
            3'd1: q.push_back(pack(1'b0, oh(x), 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
            3'd2, 3'd3: begin
                q.push_back(pack(1'b0, 8'h00, oh(x), 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
                q.push_back(pack(1'b0, 8'h00, oh(y), 1'b0, 1'b0, 1'b0, 1'b1, op == 3'd3, 1'b0));
                q.push_back(pack(1'b0, oh(x), 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1));
            end
            default: q.push_back(pack(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
        endcase
    endtask

    task automatic step(input logic run, input logic [8:0] din, input string tag);
        @(negedge Clock);
        Run = run;
        DIN = din;
        #1;
        check(tag, outs, cur_exp(run));
        check("bus_one_driver", 23'($countones({Rout, DINout, Gout}) <= 1), 23'd1);
        if (q.size() == 0) begin
            if (run) expand(din);
        end else begin
            void'(q.pop_front());
        end
    endtask

    task automatic reset_pulse(input string tag);
        @(negedge Clock);
        Run = 1'b1;
        #1;
        check({tag, "_pre"}, outs, cur_exp(1'b1));
        #1;
        Reset = 1'b1;
        #1;
        check({tag, "_async"}, outs, 23'd0);
        check({tag, "_ir"}, 23'(dut.ir), 23'd0);
        q.delete();
        @(negedge Clock);
        Run   = 1'b0;
        Reset = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        Reset  = 1'b1;
        Run    = 1'b1;
        DIN    = 9'h000;
        #1;
        check("reset_outs", outs, 23'd0);
        check("reset_ir", 23'(dut.ir), 23'd0);
        @(negedge Clock);
        Run   = 1'b0;
        Reset = 1'b0;

        // mvi R3,#5
        step(1'b1, 9'b001_011_000, "mvi_fetch");
        step(1'b0, 9'h005,         "mvi_t1");
        step(1'b0, 9'h000,         "mvi_back_t0");
        // mv R1,R6
        step(1'b1, 9'b000_001_110, "mv_fetch");
        step(1'b0, 9'h000,         "mv_t1");
        // sub R2,R7 then add R2,R7, Run dropped mid-instruction
        step(1'b1, 9'b011_010_111, "sub_fetch");
        step(1'b0, 9'h000,         "sub_t1");
        step(1'b0, 9'h000,         "sub_t2");
        step(1'b0, 9'h000,         "sub_t3");
        step(1'b1, 9'b010_010_111, "add_fetch");
        step(1'b1, 9'h1ff,         "add_t1");
        step(1'b1, 9'h1ff,         "add_t2");
        step(1'b1, 9'h1ff,         "add_t3");
        // NOP followed by an mv with Run held high
        step(1'b1, 9'b111_000_000, "nop_fetch");
        step(1'b1, 9'b000_001_110, "nop_t1");
        step(1'b1, 9'b000_001_110, "mv2_fetch");
        step(1'b0, 9'h000,         "mv2_t1");
        // reset during T2 of an add
        step(1'b1, 9'b010_101_011, "radd_fetch");
        step(1'b0, 9'h000,         "radd_t1");
        reset_pulse("radd_t2");
        step(1'b1, 9'b000_111_000, "after_reset_fetch");
        step(1'b0, 9'h000,         "after_reset_t1");

        // randomized traffic with occasional asynchronous resets
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 59) == 0) begin
                reset_pulse("rand_reset");
            end else begin
                step($urandom_range(0, 3) != 0, 9'($urandom), "rand");
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
